// File: rtl/uart_wb_bridge.sv
// Serial byte-frame to Wishbone classic master bridge.
// Decodes read/write command frames, runs one bus cycle, returns status (+ read data).
module uart_wb_bridge #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BUS_TIMEOUT  = 1024,
  parameter int IDLE_TIMEOUT = 720000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  output logic                  busy
);

  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int IT_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_ERR = 8'hEE;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t          state, state_n;
  logic            cmd_we;
  logic [1:0]      byte_cnt;
  logic [31:0]     adr_q;
  logic [DATA_WIDTH-1:0] wdat_q, rdat_q;
  logic [7:0]      status_q;
  logic [2:0]      tx_idx, resp_last;
  logic [BT_W-1:0] bus_cnt;
  logic [IT_W-1:0] idle_cnt;
  logic            cmd_ok, bus_to, idle_to, tx_fire;

  assign cmd_ok    = (rx_data == CMD_RD) || (rx_data == CMD_WR);
  assign bus_to    = (bus_cnt == BT_W'(BUS_TIMEOUT - 1));
  assign idle_to   = !rx_valid && (idle_cnt == IT_W'(IDLE_TIMEOUT - 1));
  assign tx_fire   = tx_valid && tx_ready;
  // Only a successful read carries the 4 data bytes behind the status byte.
  assign resp_last = (status_q == ST_OK && !cmd_we) ? 3'd4 : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (rx_valid) state_n = cmd_ok ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (rx_valid && byte_cnt == 2'd3) state_n = cmd_we ? S_DATA : S_BUS;
        else if (idle_to)                 state_n = S_IDLE;
      end
      S_DATA: begin
        if (rx_valid && byte_cnt == 2'd3) state_n = S_BUS;
        else if (idle_to)                 state_n = S_IDLE;
      end
      S_BUS:  if (wbm_ack_i || wbm_err_i || bus_to) state_n = S_RESP;
      S_RESP: if (tx_ready && tx_idx == resp_last)  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_we   <= 1'b0;
      byte_cnt <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      tx_idx   <= '0;
      bus_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_idx <= '0;
          if (rx_valid) begin
            if (cmd_ok) begin
              cmd_we   <= (rx_data == CMD_WR);
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              status_q <= ST_ERR;
            end
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            if (state == S_ADDR) adr_q  <= {adr_q[23:0], rx_data};
            else                 wdat_q <= {wdat_q[DATA_WIDTH-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= '0;
            bus_cnt  <= '0;
          end else begin
            idle_cnt <= idle_cnt + IT_W'(1);
          end
        end
        S_BUS: begin
          tx_idx  <= '0;
          bus_cnt <= bus_cnt + BT_W'(1);
          // ack together with err is treated as an error.
          if (wbm_err_i) begin
            status_q <= ST_ERR;
          end else if (wbm_ack_i) begin
            status_q <= ST_OK;
            if (!cmd_we) rdat_q <= wbm_dat_i;
          end else if (bus_to) begin
            status_q <= ST_ERR;
          end
        end
        S_RESP: if (tx_fire) tx_idx <= tx_idx + 3'd1;
        default: ;
      endcase
    end
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  assign busy      = (state != S_IDLE);
  assign wbm_cyc_o = (state == S_BUS);
  assign wbm_stb_o = (state == S_BUS);
  assign wbm_we_o  = (state == S_BUS) && cmd_we;
  assign wbm_sel_o = (state == S_BUS) ? 4'hF : 4'h0;
  assign wbm_adr_o = adr_q[ADDR_WIDTH-1:0];
  assign wbm_dat_o = wdat_q;
  assign tx_valid  = (state == S_RESP);

  always_comb begin
    tx_data = 8'h00;
    if (state == S_RESP) begin
      case (tx_idx)
        3'd0:    tx_data = status_q;
        3'd1:    tx_data = rdat_q[31:24];
        3'd2:    tx_data = rdat_q[23:16];
        3'd3:    tx_data = rdat_q[15:8];
        3'd4:    tx_data = rdat_q[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Self-checking bench for uart_wb_bridge: directed frames plus random frames
// checked against a register-map model of the bus.
`timescale 1ns/1ps
module tb_uart_wb_bridge;

  localparam int BT = 16;
  localparam int IT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
  logic        busy;

  uart_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BUS_TIMEOUT(BT), .IDLE_TIMEOUT(IT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave: 0 = ack after ack_delay, 1 = never responds, 2 = ack+err together
  int          slave_mode = 0;
  int          ack_delay  = 3;
  int          wait_cnt   = 0;
  logic [31:0] slave_mem [logic [31:0]];

  always @(posedge clk) begin
    if (rst) begin
      wbm_ack_i <= 1'b0; wbm_err_i <= 1'b0; wait_cnt <= 0;
    end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
      if (slave_mode != 1 && wait_cnt >= ack_delay) begin
        wbm_ack_i <= 1'b1;
        wbm_err_i <= (slave_mode == 2);
        if (slave_mode == 0 && wbm_we_o) slave_mem[wbm_adr_o] = wbm_dat_o;
        wbm_dat_i <= slave_mem.exists(wbm_adr_o) ? slave_mem[wbm_adr_o] : 32'h0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wbm_ack_i <= 1'b0; wbm_err_i <= 1'b0; wait_cnt <= 0;
    end
  end

  // Bus / tx monitors
  logic [7:0]  got_q[$];
  int          cyc_hi = 0, n_bus = 0;
  logic        prev_cyc = 1'b0, ack_seen = 1'b0, hold_pend = 1'b0;
  logic [7:0]  held_byte = '0;
  logic [31:0] log_adr = '0, log_dat = '0;
  logic        log_we = 1'b0;
  logic [3:0]  log_sel = '0;

  always @(posedge clk) begin
    if (wbm_cyc_o) cyc_hi <= cyc_hi + 1;
    if (wbm_cyc_o && !prev_cyc) n_bus <= n_bus + 1;
    prev_cyc <= wbm_cyc_o;
    if (wbm_cyc_o && (wbm_ack_i || wbm_err_i)) begin
      log_adr <= wbm_adr_o; log_dat <= wbm_dat_o; log_we <= wbm_we_o; log_sel <= wbm_sel_o;
      ack_seen <= 1'b1;
    end else begin
      ack_seen <= 1'b0;
    end
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    hold_pend <= tx_valid && !tx_ready && !rst;
    held_byte <= tx_data;
  end

  always @(negedge clk) begin
    if (ack_seen)  chk("ack_to_txvalid", {62'h0, tx_valid, wbm_cyc_o}, 64'h2);
    if (hold_pend && !rst) chk("tx_hold", {55'h0, tx_valid, tx_data}, {55'h0, 1'b1, held_byte});
  end

  int throttle = 0, rdy_cnt = 0;
  always @(negedge clk) begin
    tx_ready = (throttle != 0) ? (rdy_cnt % 4 == 0) : 1'b1;
    rdy_cnt++;
  end

  // Reference model: 32-bit register map plus expected response bytes.
  logic [31:0] model_mem [logic [31:0]];
  logic [7:0]  exp_q[$];

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    chk({tag, "_done"}, {63'h0, busy}, 64'h0);
  endtask

  task automatic check_resp(input string tag, input int base);
    chk({tag, "_len"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) chk({tag, "_byte"}, {56'h0, got_q[base + i]}, {56'h0, exp_q[i]});
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input bit ok);
    int base;
    base = got_q.size();
    send_byte(8'h02); send_word(a); send_word(d);
    exp_q = {};
    if (ok) begin model_mem[a] = d; exp_q.push_back(8'hA5); end
    else exp_q.push_back(8'hEE);
    wait_done(tag);
    check_resp(tag, base);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input bit ok);
    int base;
    logic [31:0] v;
    base = got_q.size();
    send_byte(8'h01); send_word(a);
    exp_q = {};
    if (ok) begin
      v = model_mem.exists(a) ? model_mem[a] : 32'h0;
      exp_q.push_back(8'hA5);
      for (int i = 3; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    end else begin
      exp_q.push_back(8'hEE);
    end
    wait_done(tag);
    check_resp(tag, base);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nb0, c0;
    logic [31:0] a, d;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {56'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, tx_valid, busy, 3'b0}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {16'h0, tx_data, wbm_sel_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, tx_valid, busy}, 64'h0);
    chk("reset_bus", {wbm_adr_o, wbm_dat_o}, 64'h0);

    // Write with slave acking after a few cycles; check 1-cycle frame-to-cyc latency
    base = got_q.size(); nb0 = n_bus;
    send_byte(8'h02); send_word(32'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_cyc_latency", {61'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 64'h7);
    model_mem[32'h10] = 32'hDEADBEEF;
    exp_q = {8'hA5};
    wait_done("wr");
    check_resp("wr", base);
    chk("wr_bus", {log_adr, log_dat}, {32'h10, 32'hDEADBEEF});
    chk("wr_we_sel", {59'h0, log_we, log_sel}, {59'h0, 1'b1, 4'hF});
    chk("wr_one_cycle", 64'(n_bus - nb0), 64'd1);

    // Read back with throttled transmitter
    do_write("wr8", 32'h8, 32'h12345678, 1'b1);
    throttle = 1;
    do_read("rd8", 32'h8, 1'b1);
    chk("rd_we", {63'h0, log_we}, 64'h0);
    throttle = 0;

    // Bad command: no bus cycle, EE, then a valid read
    base = got_q.size(); nb0 = n_bus;
    send_byte(8'h7F);
    exp_q = {8'hEE};
    wait_done("badcmd");
    check_resp("badcmd", base);
    chk("badcmd_nobus", 64'(n_bus - nb0), 64'd0);
    do_read("after_bad", 32'h10, 1'b1);

    // Bus timeout: slave never answers
    slave_mode = 1; c0 = cyc_hi;
    do_read("timeout", 32'h20, 1'b0);
    chk("timeout_cycles", 64'(cyc_hi - c0), 64'(BT));
    slave_mode = 2;
    do_write("ack_err", 32'h24, 32'h55AA55AA, 1'b0);
    slave_mode = 0;

    // Resync after a stalled partial frame
    nb0 = n_bus;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    repeat (IT + 10) @(negedge clk);
    chk("resync_idle", {63'h0, busy}, 64'h0);
    do_read("resync_rd", 32'h8, 1'b1);
    chk("resync_bus", 64'(n_bus - nb0), 64'd1);

    // Async reset mid bus cycle
    slave_mode = 1;
    send_byte(8'h01); send_word(32'h30);
    chk("prerst_cyc", {63'h0, wbm_cyc_o}, 64'h1);
    #2 rst = 1'b1;
    #1 chk("async_rst", {60'h0, wbm_cyc_o, wbm_stb_o, tx_valid, busy}, 64'h0);
    @(negedge clk); rst = 1'b0;
    slave_mode = 0;
    do_read("post_rst", 32'h10, 1'b1);

    // Random frames against the register-map model
    for (int k = 0; k < 12; k++) begin
      a = {26'h0, 4'($urandom_range(0, 7)), 2'b00};
      d = $urandom;
      throttle = $urandom_range(0, 1);
      ack_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) do_write("rnd_wr", a, d, 1'b1);
      else                           do_read("rnd_rd", a, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
Byte-stream to Wishbone master bridge. It sits behind the ttl_serial byte interface and lets a host PC or flight-controller link issue 32-bit register reads and writes on the on-chip Wishbone bus, including to the UART and peripheral slaves. It is the initiator side of the bus that the serial slave peripherals respond to: it decodes a fixed binary command frame, runs one Wishbone classic cycle, and returns a status byte plus any read data.

Parameters:
ADDR_WIDTH, 32, Wishbone address width; the frame always carries 4 address bytes, truncated to ADDR_WIDTH.
DATA_WIDTH, 32, Wishbone data width; fixed at 32.
BUS_TIMEOUT, 1024, cycles to wait for ack/err before the bridge aborts the bus cycle.
IDLE_TIMEOUT, 720000, cycles allowed between received bytes mid-frame before resync (10 ms at 72 MHz).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  single-cycle strobe; rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter can accept; transfer when tx_valid&&tx_ready
wbm_adr_o  out  ADDR_WIDTH  bus address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave error
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Frame: CMD byte; 0x01 = read, 0x02 = write. Then ADDR[31:24..7:0] as 4 bytes, MSB first. For a write only, DATA as 4 bytes, MSB first.
- Response: 0xA5 = ok, 0xEE = bus error, timeout or bad command. A successful read is 0xA5 followed by 4 data bytes, MSB first. A write or any error returns the status byte only.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE: on rx_valid, 0x01/0x02 latches the command and goes to ADDR with byte count 0. Any other byte goes to RESP with 0xEE.
- ADDR: shifts rx_data into the address register, MSB first. On the 4th byte, a write goes to DATA and a read goes to BUS.
- DATA: same as ADDR for wdata. On the 4th byte, go to BUS.
- BUS: first cycle in BUS asserts cyc, stb and sel=F, and sets we for a write.
  - Hold until ack_i or err_i. On that cycle, deassert cyc/stb/we on the next edge and capture dat_i for a read.
  - ack and err together count as err.
  - The timeout counter starts at entry to BUS. When it reaches BUS_TIMEOUT-1 with no ack/err, drop cyc/stb and respond 0xEE.
- RESP: presents bytes one at a time on tx_data with tx_valid=1. The byte advances on each tx_valid&&tx_ready. After the last byte, tx_valid is 0 on the next cycle and the state returns to IDLE.
- Latency:
  - Last rx byte to cyc high: 1 cycle.
  - ack to tx_valid high: 1 cycle.
- rx_valid in BUS or RESP: byte discarded; no queueing.
- Inter-byte timeout: in ADDR/DATA the counter resets on each rx_valid. Reaching IDLE_TIMEOUT discards the partial frame and returns to IDLE with no response.
- rst mid-cycle drops cyc/stb immediately (async) and discards the frame.
- Address and data registers persist after a frame. Only busy and the bus strobes are cleared.

Test Plan:
- Write: rx 02 00 00 00 10 DE AD BE EF -> one cycle with adr=0x10, dat_o=0xDEADBEEF, we=1, sel=F. Slave acks after 3 cycles -> tx 0xA5 only; busy falls after the tx handshake.
- Read: rx 01 00 00 00 08, slave returns 0x12345678 with ack -> we=0; tx A5 12 34 56 78 in order. With tx_ready toggling 1-of-4 cycles, the bytes stay held and no byte is lost or duplicated.
- Bad command: rx 0x7F -> no bus cycle; tx 0xEE; back to IDLE, then a valid read succeeds.
- Bus timeout (BUS_TIMEOUT=16): read to a slave that never acks -> cyc drops after 16 cycles; tx 0xEE. A slave asserting ack and err together -> 0xEE.
- Resync (IDLE_TIMEOUT=100): rx 02 00 00, idle 100 cycles, then a full read frame -> the partial frame is discarded and the read completes normally with 5 response bytes.
- Async rst asserted while cyc=1 -> cyc/stb/tx_valid drop without waiting for a clock edge; busy=0; the next frame works.
